// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS single-bus controller.
package mips_bus_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StData,
    StCommit,
    StHalted
  } bus_state_e;

  // Fetching this PC ends execution
  localparam logic [31:0] HaltAddrDefault = 32'h0000_0000;

  // Bus addresses are always word aligned
  localparam logic [31:0] WordMask = 32'hFFFF_FFFC;

endpackage

// File: rtl/bus_capreg.sv
// 32-bit capture register with load enable and async active-low reset.
module bus_capreg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] r_q;

  // Hold value except on a load edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 32'h0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mips_bus_ctrl.sv
// Multi-cycle bus controller: sequences instruction fetch, optional data
// access and a one-cycle commit strobe over a single shared memory bus.
module mips_bus_ctrl
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = HaltAddrDefault
) (
  input  logic        clk,
  input  logic        reset,
  // Datapath side
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  // Memory bus
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        active
);

  bus_state_e r_state;
  logic       r_is_write;
  logic       w_halt;
  logic       w_instr_load;
  logic       w_data_load;

  assign w_halt = (instr_address == HALT_ADDR);

  // Sequencing FSM; direction of the data access is latched in EXEC so that
  // a simultaneous read+write request resolves to a write for the whole access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_is_write <= 1'b0;
    end else begin
      case (r_state)
        StIdle:   r_state <= StFetch;
        StFetch: begin
          if (w_halt) begin
            r_state <= StHalted;
          end else if (!waitrequest) begin
            r_state <= StExec;
          end
        end
        StExec: begin
          if (data_write) begin
            r_is_write <= 1'b1;
            r_state    <= StData;
          end else if (data_read) begin
            r_is_write <= 1'b0;
            r_state    <= StData;
          end else begin
            r_state <= StCommit;
          end
        end
        StData: begin
          if (!waitrequest) begin
            r_state <= StCommit;
          end
        end
        StCommit: r_state <= StFetch;
        StHalted: r_state <= StHalted;
        default:  r_state <= StIdle;
      endcase
    end
  end

  // Bus and strobe decode from the state register. The PC only moves on the
  // commit edge, so the fetch address must follow the live datapath input.
  always_comb begin
    read       = 1'b0;
    write      = 1'b0;
    address    = 32'h0;
    writedata  = 32'h0;
    byteenable = 4'h0;
    clk_enable = 1'b0;
    active     = 1'b0;
    case (r_state)
      StFetch: begin
        active = 1'b1;
        if (!w_halt) begin
          read       = 1'b1;
          address    = instr_address & WordMask;
          byteenable = 4'hF;
        end
      end
      StExec: begin
        active = 1'b1;
      end
      StData: begin
        active     = 1'b1;
        address    = data_address & WordMask;
        byteenable = data_byteenable;
        if (r_is_write) begin
          write     = 1'b1;
          writedata = data_writedata;
        end else begin
          read = 1'b1;
        end
      end
      StCommit: begin
        active     = 1'b1;
        clk_enable = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign w_instr_load = (r_state == StFetch) && !w_halt && !waitrequest;
  assign w_data_load  = (r_state == StData) && !r_is_write && !waitrequest;

  bus_capreg u_instr_cap (
    .clk    (clk),
    .rst_n  (reset),
    .i_load (w_instr_load),
    .i_d    (readdata),
    .o_q    (instr_readdata)
  );

  bus_capreg u_data_cap (
    .clk    (clk),
    .rst_n  (reset),
    .i_load (w_data_load),
    .i_d    (readdata),
    .o_q    (data_readdata)
  );

endmodule

// File: tb/tb_mips_bus_ctrl.sv
// Self-checking bench for mips_bus_ctrl: the bench plays both datapath and
// memory, and predicts latency and captured data from transaction contents.
module tb_mips_bus_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        clk_enable;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        active;

  mips_bus_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .data_address    (data_address),
    .data_writedata  (data_writedata),
    .data_read       (data_read),
    .data_write      (data_write),
    .data_byteenable (data_byteenable),
    .data_readdata   (data_readdata),
    .clk_enable      (clk_enable),
    .address         (address),
    .read            (read),
    .write           (write),
    .writedata       (writedata),
    .byteenable      (byteenable),
    .readdata        (readdata),
    .waitrequest     (waitrequest),
    .active          (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rd;
    logic        wr;
    logic [31:0] daddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          fw;
    int          dw;
    int          exp_cycles;
  } vec_t;

  int          n_cmp;
  int          n_fail;
  logic [31:0] exp_dr;
  vec_t        vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Latency from the transaction's shape: fetch + exec + commit, one more
  // for a data access, one per wait cycle.
  function automatic int model_cycles(input vec_t t);
    return 3 + t.fw + ((t.rd || t.wr) ? 1 + t.dw : 0);
  endfunction

  // Run one instruction starting in FETCH (called at edge+1); ends at edge+1
  // after the commit edge.
  task automatic do_txn(input vec_t t, input string tag);
    int          cyc;
    int          commit_at;
    int          n_ce;
    int          f_cyc;
    int          d_cyc;
    int          n_wr_done;
    int          n_rd_done;
    int          exp_d;
    bit          phase_data;
    bit          both_hi;
    bit          bad_bus;
    bit          bad_act;
    bit          done;
    logic [31:0] exp_fa;
    logic [31:0] exp_da;
    cyc = 0; commit_at = 0; n_ce = 0; f_cyc = 0; d_cyc = 0;
    n_wr_done = 0; n_rd_done = 0;
    phase_data = 0; both_hi = 0; bad_bus = 0; bad_act = 0; done = 0;
    exp_fa = {t.pc[31:2], 2'b00};
    exp_da = {t.daddr[31:2], 2'b00};
    instr_address   = t.pc;
    data_address    = t.daddr;
    data_read       = t.rd;
    data_write      = t.wr;
    data_byteenable = t.be;
    data_writedata  = t.wdata;
    #1;
    for (int c = 0; c < 60 && !done; c++) begin
      cyc++;
      if (read && write) both_hi = 1;
      if (!active) bad_act = 1;
      if (clk_enable) begin
        n_ce++;
        commit_at = cyc;
      end
      if (read || write) begin
        if (!phase_data) begin
          f_cyc++;
          if (write || address !== exp_fa || byteenable !== 4'hF) bad_bus = 1;
          if (f_cyc <= t.fw) begin
            waitrequest = 1'b1;
            readdata    = $urandom;
          end else begin
            waitrequest = 1'b0;
            readdata    = t.instr;
            phase_data  = 1;
          end
        end else begin
          d_cyc++;
          if (address !== exp_da || byteenable !== t.be) bad_bus = 1;
          if (t.wr ? (!write || writedata !== t.wdata) : !read) bad_bus = 1;
          if (d_cyc <= t.dw) begin
            waitrequest = 1'b1;
            readdata    = $urandom;
          end else begin
            waitrequest = 1'b0;
            readdata    = t.rdata;
            if (write) n_wr_done++;
            else n_rd_done++;
          end
        end
      end else begin
        // Idle bus: noise on waitrequest/readdata must be ignored
        waitrequest = 1'($urandom_range(0, 1));
        readdata    = $urandom;
      end
      @(posedge clk);
      #1;
      if (commit_at != 0) done = 1;
    end
    if (t.rd && !t.wr) exp_dr = t.rdata;
    exp_d = (t.rd || t.wr) ? 1 + t.dw : 0;
    chk({tag, " commit cycle"}, commit_at, t.exp_cycles);
    chk({tag, " commit count"}, n_ce, 1);
    chk({tag, " read+write together"}, both_hi, 0);
    chk({tag, " bus fields"}, bad_bus, 0);
    chk({tag, " active low mid-txn"}, bad_act, 0);
    chk({tag, " fetch cycles"}, f_cyc, 1 + t.fw);
    chk({tag, " data cycles"}, d_cyc, exp_d);
    chk({tag, " writes done"}, n_wr_done, t.wr ? 1 : 0);
    chk({tag, " data reads done"}, n_rd_done, (t.rd && !t.wr) ? 1 : 0);
    chk({tag, " instr_readdata"}, instr_readdata, t.instr);
    chk({tag, " data_readdata"}, data_readdata, exp_dr);
    chk({tag, " clk_enable after commit"}, clk_enable, 0);
  endtask

  initial begin
    int   n_bus;
    vec_t r;
    n_cmp = 0;
    n_fail = 0;
    exp_dr = 32'h0;

    //          pc            instr         rd wr daddr         be      wdata         rdata         fw dw cyc
    vecs[0] = '{32'h0000_0004, 32'h0022_1821, 0, 0, 32'h0,        4'hF,   32'h0,        32'h0,        0, 0, 3};
    vecs[1] = '{32'h0000_0008, 32'h8C22_0003, 1, 0, 32'h0000_1003, 4'hF,   32'h0,        32'hDEAD_BEEF, 0, 2, 6};
    vecs[2] = '{32'h0000_000C, 32'hAC22_0000, 0, 1, 32'h0000_2000, 4'b0011, 32'h1234_5678, 32'h0,        0, 0, 4};
    vecs[3] = '{32'h0000_0010, 32'hAC23_0004, 1, 1, 32'h0000_2004, 4'hF,   32'hCAFE_F00D, 32'h5555_5555, 0, 0, 4};
    vecs[4] = '{32'h0000_0015, 32'h0043_2021, 0, 0, 32'h0,        4'hF,   32'h0,        32'h0,        3, 0, 6};
    vecs[5] = '{32'h0000_0020, 32'h8C44_0002, 1, 0, 32'h0000_3002, 4'b1100, 32'h0,        32'hA5A5_0F0F, 1, 1, 6};

    instr_address = 32'h4; data_address = 0; data_writedata = 0;
    data_read = 0; data_write = 0; data_byteenable = 0;
    readdata = 0; waitrequest = 0;

    // Asynchronous reset before any clock edge
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset strobes", {28'h0, read, write, clk_enable, active}, 32'h0);
    chk("reset address", address, 32'h0);
    chk("reset writedata", writedata, 32'h0);
    chk("reset byteenable", {28'h0, byteenable}, 32'h0);
    chk("reset instr_readdata", instr_readdata, 32'h0);
    chk("reset data_readdata", data_readdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("idle active", active, 0);
    chk("idle read", read, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      r.pc    = $urandom;
      if (r.pc == 32'h0) r.pc = 32'h4;
      r.instr = $urandom;
      r.rd    = 1'($urandom_range(0, 1));
      r.wr    = 1'($urandom_range(0, 1));
      r.daddr = $urandom;
      r.be    = 4'($urandom);
      r.wdata = $urandom;
      r.rdata = $urandom;
      r.fw    = $urandom_range(0, 2);
      r.dw    = $urandom_range(0, 2);
      r.exp_cycles = model_cycles(r);
      do_txn(r, $sformatf("rnd%0d", i));
    end

    // Reset while a load sits in DATA with waitrequest held high
    instr_address = 32'h100; data_read = 1; data_write = 0;
    data_address = 32'h3000; data_byteenable = 4'hF;
    #1;
    chk("rst seq fetch read", read, 1);
    waitrequest = 1'b0;
    readdata = 32'h8C25_0000;
    @(posedge clk);
    #1;
    waitrequest = 1'b1;
    readdata = 32'h7777_7777;
    @(posedge clk);
    #1;
    chk("rst seq data read", read, 1);
    chk("rst seq data address", address, 32'h3000);
    #2 reset = 1'b0;
    #1;
    chk("rst seq strobes", {28'h0, read, write, clk_enable, active}, 32'h0);
    chk("rst seq data_readdata", data_readdata, 32'h0);
    chk("rst seq instr_readdata", instr_readdata, 32'h0);
    exp_dr = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst seq idle clk_enable", clk_enable, 0);
    chk("rst seq idle active", active, 0);
    @(posedge clk);
    #1;
    do_txn(vecs[0], "after reset");

    // Fetch of the halt address: no bus cycle, then absorbing HALTED
    instr_address = 32'h0; data_read = 0; data_write = 0;
    #1;
    chk("halt fetch active", active, 1);
    chk("halt fetch read", read, 0);
    @(posedge clk);
    #1;
    chk("halted active", active, 0);
    n_bus = 0;
    for (int c = 0; c < 20; c++) begin
      if (read || write || clk_enable || active) n_bus++;
      waitrequest = 1'($urandom_range(0, 1));
      readdata = $urandom;
      @(posedge clk);
      #1;
    end
    chk("halted activity cycles", n_bus, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
